// File: rtl/video_timing_pkg.sv
// video_timing_pkg
// Shared timing types, mode presets and the axis total helper used by the
// raster generator. No ports: import with video_timing_pkg::*.
package video_timing_pkg;

  // One axis of a mode: visible span followed by front porch, sync, back porch.
  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } axis_timing_t;

  typedef struct packed {
    axis_timing_t h;
    axis_timing_t v;
    int           pixel_rep;
    int           line_rep;
  } video_mode_t;

  // Standard 640x480@60, no replication.
  localparam video_mode_t VGA640X480 = '{
    h: '{640, 16, 96, 48},
    v: '{480, 10, 2, 33},
    pixel_rep: 1,
    line_rep: 1
  };

  // Wide panel timing carrying 240 native lines.
  localparam video_mode_t WIDE1706X240 = '{
    h: '{1706, 24, 80, 150},
    v: '{240, 3, 5, 14},
    pixel_rep: 1,
    line_rep: 1
  };

  // 320x240 content doubled onto the 640x480 raster.
  localparam video_mode_t QVGA320X240_REP = '{
    h: '{640, 16, 96, 48},
    v: '{480, 10, 2, 33},
    pixel_rep: 2,
    line_rep: 2
  };

  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/video_timing_gen_axis.sv
// video_axis_counter
// One raster axis: position counter, sync level, active flag and replicated
// logical coordinate. All level outputs are registered from the next count so
// they line up with the count presented in the same cycle.
// Ports:
//   clk, nreset      clock, asynchronous active-low reset
//   tick, enable     advance by one when both are 1; enable=0 freezes state
//   count            current position 0..TOTAL-1
//   count_next       position that will be loaded on the next edge
//   sync             sync level (POL while in the sync region)
//   active           count < ACTIVE
//   coordinate       count/REP inside the active region, 0 outside
//   wrap             count is at TOTAL-1 (combinational)
module video_axis_counter
  import video_timing_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int REP    = 1,
  parameter bit POL    = 1'b0,
  parameter int CW     = 12
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          tick,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_next,
  output logic          sync,
  output logic          active,
  output logic [CW-1:0] coordinate,
  output logic          wrap
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ACT_END    = CW'(ACTIVE);
  localparam logic [CW-1:0] SYNC_START = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] SYNC_END   = CW'(ACTIVE + FP + SYNC);
  localparam int RW = 2;
  localparam logic [RW-1:0] REP_LAST = RW'(REP - 1);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] coord_reg;
  logic [CW-1:0] coord_next;
  logic [RW-1:0] rep_reg;
  logic [RW-1:0] rep_next;
  logic          sync_reg;
  logic          active_reg;
  logic          step;

  assign wrap = (count_reg == LAST);
  assign step = enable && tick;

  // Replication: rep_reg walks 0..REP-1 and the coordinate steps when it
  // rolls over. Leaving the active region or wrapping clears both, so the
  // coordinate reads 0 in blanking without any divider.
  always_comb begin
    count_next = count_reg;
    coord_next = coord_reg;
    rep_next   = rep_reg;
    if (step) begin
      if (wrap) begin
        count_next = '0;
        coord_next = '0;
        rep_next   = '0;
      end else begin
        count_next = count_reg + CW'(1);
        if (count_next < ACT_END) begin
          if (rep_reg == REP_LAST) begin
            rep_next   = '0;
            coord_next = coord_reg + CW'(1);
          end else begin
            rep_next = rep_reg + RW'(1);
          end
        end else begin
          rep_next   = '0;
          coord_next = '0;
        end
      end
    end
  end

  // Levels refresh on every enabled edge, not just on tick, so the vertical
  // axis leaves its reset idle state on the very first enabled pixel clock.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      count_reg  <= '0;
      coord_reg  <= '0;
      rep_reg    <= '0;
      sync_reg   <= ~POL;
      active_reg <= 1'b0;
    end else if (enable) begin
      count_reg  <= count_next;
      coord_reg  <= coord_next;
      rep_reg    <= rep_next;
      sync_reg   <= ((count_next >= SYNC_START) && (count_next < SYNC_END)) ? POL : ~POL;
      active_reg <= (count_next < ACT_END);
    end
  end

  assign count      = count_reg;
  assign coordinate = coord_reg;
  assign sync       = sync_reg;
  assign active     = active_reg;

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen
// Parametrised raster timing generator with pixel/line replication.
// Ports:
//   clkPixel, nreset       pixel clock, asynchronous active-low reset
//   enable                 advance raster when 1, hold (and mute pulses) when 0
//   h_count, v_count       raster position
//   hsync, vsync, de       sync levels and active-video flag
//   px_x, px_y             replicated logical coordinates, 0 outside active
//   line_start             pulse at h=0 of an active line
//   frame_start            pulse at h=0, v=0
//   frameDrawn             pulse at h=0, v=V_ACTIVE (CPU interrupt)
//   prefetch               pulse PREFETCH clocks before an active line starts
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int PIXEL_REP = 2,
  parameter int LINE_REP  = 2,
  parameter int PREFETCH  = 32,
  parameter int CW        = 12
) (
  input  logic          clkPixel,
  input  logic          nreset,
  input  logic          enable,
  output logic [CW-1:0] h_count,
  output logic [CW-1:0] v_count,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] px_x,
  output logic [CW-1:0] px_y,
  output logic          line_start,
  output logic          frame_start,
  output logic          frameDrawn,
  output logic          prefetch
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam logic [CW-1:0] PF_POS   = CW'(H_TOTAL - PREFETCH);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_ACT_M1 = CW'(V_ACTIVE - 1);

  if (PIXEL_REP < 1 || PIXEL_REP > 4 || LINE_REP < 1 || LINE_REP > 4) begin : g_bad_rep
    $error("video_timing_gen: PIXEL_REP and LINE_REP must be 1..4");
  end
  if ((H_ACTIVE % PIXEL_REP) != 0 || (V_ACTIVE % LINE_REP) != 0) begin : g_bad_div
    $error("video_timing_gen: active size not a multiple of replication");
  end
  if (H_TOTAL >= (1 << CW) || V_TOTAL >= (1 << CW)) begin : g_bad_cw
    $error("video_timing_gen: totals do not fit in CW bits");
  end
  if (PREFETCH < 1 || PREFETCH > H_FP + H_SYNC + H_BP) begin : g_bad_pf
    $error("video_timing_gen: PREFETCH must lie within horizontal blanking");
  end

  logic [CW-1:0] h_next;
  logic [CW-1:0] v_next;
  logic          h_wrap;
  logic          v_wrap;
  logic          h_active;
  logic          v_active;

  video_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
    .REP(PIXEL_REP), .POL(HS_POL), .CW(CW)
  ) u_h_axis (
    .clk(clkPixel), .nreset(nreset), .tick(1'b1), .enable(enable),
    .count(h_count), .count_next(h_next), .sync(hsync), .active(h_active),
    .coordinate(px_x), .wrap(h_wrap)
  );

  video_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
    .REP(LINE_REP), .POL(VS_POL), .CW(CW)
  ) u_v_axis (
    .clk(clkPixel), .nreset(nreset), .tick(h_wrap), .enable(enable),
    .count(v_count), .count_next(v_next), .sync(vsync), .active(v_active),
    .coordinate(px_y), .wrap(v_wrap)
  );

  // Both factors are flop outputs updated on the same edge.
  assign de = h_active && v_active;

  // Pulses decode the position about to be loaded. h_next can only be 0 via
  // an enabled wrap, so h_wrap stands in for "h_next == 0".
  logic line_start_next;
  logic frame_start_next;
  logic frame_drawn_next;
  logic prefetch_next;

  always_comb begin
    line_start_next  = 1'b0;
    frame_start_next = 1'b0;
    frame_drawn_next = 1'b0;
    prefetch_next    = 1'b0;
    if (enable) begin
      line_start_next  = h_wrap && (v_next < V_ACT);
      frame_start_next = h_wrap && v_wrap;
      frame_drawn_next = h_wrap && (v_next == V_ACT);
      // Next line is active either inside the active span or when this is
      // the last blank line and v is about to wrap to 0.
      prefetch_next    = (h_next == PF_POS) && ((v_next == V_LAST) || (v_next < V_ACT_M1));
    end
  end

  logic line_start_reg;
  logic frame_start_reg;
  logic frame_drawn_reg;
  logic prefetch_reg;

  always_ff @(posedge clkPixel or negedge nreset) begin
    if (!nreset) begin
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      frame_drawn_reg <= 1'b0;
      prefetch_reg    <= 1'b0;
    end else begin
      line_start_reg  <= line_start_next;
      frame_start_reg <= frame_start_next;
      frame_drawn_reg <= frame_drawn_next;
      prefetch_reg    <= prefetch_next;
    end
  end

  assign line_start  = line_start_reg;
  assign frame_start = frame_start_reg;
  assign frameDrawn  = frame_drawn_reg;
  assign prefetch    = prefetch_reg;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen
// Three small-mode instances share clock, reset and enable:
//   A: H 8/2/2/2, V 4/1/1/1, rep 2x2, PREFETCH 3, active-low syncs
//   B: same timing as A with active-high syncs
//   C: H 12/2/3/3, V 6/1/2/1, rep 3x3, PREFETCH 8 (the upper limit)
// A position-based model predicts every output of every instance each cycle;
// directed checks pin specific hand-computed values.
module tb_video_timing_gen;

  typedef struct packed {
    int ha; int hf; int hs; int hb;
    int va; int vf; int vs; int vb;
    int pr; int lr; int pf;
  } mode_t;

  typedef struct packed {
    int h; int v;
    bit hs; bit vs; bit de;
    int px; int py;
    bit ls; bit fs; bit fd; bit pf;
  } exp_t;

  localparam mode_t MA = '{8, 2, 2, 2, 4, 1, 1, 1, 2, 2, 3};
  localparam mode_t MC = '{12, 2, 3, 3, 6, 1, 2, 1, 3, 3, 8};

  logic clk = 1'b0;
  logic nreset;
  logic enable;
  always #5 clk = ~clk;

  logic [7:0] a_h, a_v, a_px, a_py;
  logic a_hs, a_vs, a_de, a_ls, a_fs, a_fd, a_pf;
  logic [7:0] b_h, b_v, b_px, b_py;
  logic b_hs, b_vs, b_de, b_ls, b_fs, b_fd, b_pf;
  logic [5:0] c_h, c_v, c_px, c_py;
  logic c_hs, c_vs, c_de, c_ls, c_fs, c_fd, c_pf;

  video_timing_gen #(
    .H_ACTIVE(MA.ha), .H_FP(MA.hf), .H_SYNC(MA.hs), .H_BP(MA.hb),
    .V_ACTIVE(MA.va), .V_FP(MA.vf), .V_SYNC(MA.vs), .V_BP(MA.vb),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIXEL_REP(MA.pr), .LINE_REP(MA.lr),
    .PREFETCH(MA.pf), .CW(8)
  ) dut_a (
    .clkPixel(clk), .nreset(nreset), .enable(enable),
    .h_count(a_h), .v_count(a_v), .hsync(a_hs), .vsync(a_vs), .de(a_de),
    .px_x(a_px), .px_y(a_py), .line_start(a_ls), .frame_start(a_fs),
    .frameDrawn(a_fd), .prefetch(a_pf)
  );

  video_timing_gen #(
    .H_ACTIVE(MA.ha), .H_FP(MA.hf), .H_SYNC(MA.hs), .H_BP(MA.hb),
    .V_ACTIVE(MA.va), .V_FP(MA.vf), .V_SYNC(MA.vs), .V_BP(MA.vb),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIXEL_REP(MA.pr), .LINE_REP(MA.lr),
    .PREFETCH(MA.pf), .CW(8)
  ) dut_b (
    .clkPixel(clk), .nreset(nreset), .enable(enable),
    .h_count(b_h), .v_count(b_v), .hsync(b_hs), .vsync(b_vs), .de(b_de),
    .px_x(b_px), .px_y(b_py), .line_start(b_ls), .frame_start(b_fs),
    .frameDrawn(b_fd), .prefetch(b_pf)
  );

  video_timing_gen #(
    .H_ACTIVE(MC.ha), .H_FP(MC.hf), .H_SYNC(MC.hs), .H_BP(MC.hb),
    .V_ACTIVE(MC.va), .V_FP(MC.vf), .V_SYNC(MC.vs), .V_BP(MC.vb),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIXEL_REP(MC.pr), .LINE_REP(MC.lr),
    .PREFETCH(MC.pf), .CW(6)
  ) dut_c (
    .clkPixel(clk), .nreset(nreset), .enable(enable),
    .h_count(c_h), .v_count(c_v), .hsync(c_hs), .vsync(c_vs), .de(c_de),
    .px_x(c_px), .px_y(c_py), .line_start(c_ls), .frame_start(c_fs),
    .frameDrawn(c_fd), .prefetch(c_pf)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int fd_q[$];

  // ---------------- behavioural model ----------------
  function automatic mode_t mode_of(input int i);
    return (i == 2) ? MC : MA;
  endfunction

  function automatic int frame_len(input mode_t m);
    return (m.ha + m.hf + m.hs + m.hb) * (m.va + m.vf + m.vs + m.vb);
  endfunction

  // Expected outputs from the linear position within the frame.
  // dec: an enabled edge has happened since reset; en: the last edge was enabled.
  function automatic exp_t model(input mode_t m, input int pos, input bit dec,
                                 input bit en, input bit pol);
    exp_t e;
    int ht, vt, h, v;
    ht = m.ha + m.hf + m.hs + m.hb;
    vt = m.va + m.vf + m.vs + m.vb;
    h = pos % ht;
    v = pos / ht;
    e = '0;
    e.h = h;
    e.v = v;
    e.hs = ~pol;
    e.vs = ~pol;
    if (dec) begin
      if (h >= m.ha + m.hf && h < m.ha + m.hf + m.hs) e.hs = pol;
      if (v >= m.va + m.vf && v < m.va + m.vf + m.vs) e.vs = pol;
      e.de = (h < m.ha) && (v < m.va);
      e.px = (h < m.ha) ? h / m.pr : 0;
      e.py = (v < m.va) ? v / m.lr : 0;
      if (en) begin
        e.ls = (h == 0) && (v < m.va);
        e.fs = (h == 0) && (v == 0);
        e.fd = (h == 0) && (v == m.va);
        e.pf = (h == ht - m.pf) && (((v + 1) % vt) < m.va);
      end
    end
    return e;
  endfunction

  function automatic exp_t mk(input int h, input int v, input bit hs, input bit vs,
                              input bit de, input int px, input int py, input bit ls,
                              input bit fs, input bit fd, input bit pf);
    exp_t r;
    r.h = h; r.v = v; r.hs = hs; r.vs = vs; r.de = de; r.px = px; r.py = py;
    r.ls = ls; r.fs = fs; r.fd = fd; r.pf = pf;
    return r;
  endfunction

  function automatic exp_t actual(input int i);
    case (i)
      0: return mk(a_h, a_v, a_hs, a_vs, a_de, a_px, a_py, a_ls, a_fs, a_fd, a_pf);
      1: return mk(b_h, b_v, b_hs, b_vs, b_de, b_px, b_py, b_ls, b_fs, b_fd, b_pf);
      default: return mk(c_h, c_v, c_hs, c_vs, c_de, c_px, c_py, c_ls, c_fs, c_fd, c_pf);
    endcase
  endfunction

  function automatic string fmt(input exp_t e);
    return $sformatf("h=%0d v=%0d hs=%0b vs=%0b de=%0b px=%0d py=%0d ls=%0b fs=%0b fd=%0b pf=%0b",
                     e.h, e.v, e.hs, e.vs, e.de, e.px, e.py, e.ls, e.fs, e.fd, e.pf);
  endfunction

  int  m_pos [3];
  bit  m_dec [3];
  bit  m_en  [3];

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < 3; i++) begin
        m_pos[i] <= 0;
        m_dec[i] <= 1'b0;
        m_en[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        m_en[i] <= enable;
        if (enable) begin
          m_pos[i] <= (m_pos[i] + 1) % frame_len(mode_of(i));
          m_dec[i] <= 1'b1;
        end
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (a_fd === 1'b1) fd_q.push_back(cyc);

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    for (int i = 0; i < 3; i++) begin
      e = model(mode_of(i), m_pos[i], m_dec[i], m_en[i], (i == 1));
      a = actual(i);
      total++;
      if (a !== e) begin
        bad++;
        if (bad <= 20)
          $display("FAIL model_dut%0d cyc=%0d got {%s} want {%s}", i, cyc, fmt(a), fmt(e));
      end
    end
  end

  // ---------------- directed checks ----------------
  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end else begin
      $display("chk %s got=%0d want=%0d ok", name, got, want);
    end
  endtask

  task automatic wait_a(input int h, input int v);
    int n;
    n = 0;
    while (!(a_h == h && a_v == v) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      total++;
      bad++;
      $display("FAIL wait_a_timeout got=h%0d/v%0d want=h%0d/v%0d", a_h, a_v, h, v);
    end
  endtask

  initial begin
    int fs_cnt, de_cnt, pf_h_bad, fs_cyc, fs_to_fd, fd_h, fd_v, n0, last_fd, n, held_bad, pulse_bad;
    bit [6:0]  pf_mask;
    bit [13:0] hs_mask;
    bit [6:0]  vs_mask;
    bit [31:0] pxseq;
    bit [27:0] pyseq;
    bit c_pf_seen, c_px_seen;

    nreset = 1'b0;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_h", a_h, 0);
    chk("rst_v", a_v, 0);
    chk("rst_hsync", a_hs, 1);
    chk("rst_vsync", a_vs, 1);
    chk("rst_de", a_de, 0);
    chk("rst_b_hsync", b_hs, 0);

    nreset = 1'b1;
    @(negedge clk);
    chk("idle_hold_h", a_h, 0);
    chk("idle_hold_de", a_de, 0);

    enable = 1'b1;
    @(negedge clk);
    chk("first_h", a_h, 1);
    chk("first_v", a_v, 0);
    chk("first_de", a_de, 1);
    chk("first_fs", a_fs, 0);
    @(negedge clk);
    chk("second_px_x", a_px, 1);

    // One complete frame of A, delimited by frame_start pulses.
    fs_cnt = 0; de_cnt = 0; pf_h_bad = 0; fs_cyc = 0; fs_to_fd = -1; fd_h = -1; fd_v = -1;
    pf_mask = '0; hs_mask = '0; vs_mask = '0; pxseq = '0; pyseq = '0;
    c_pf_seen = 1'b0; c_px_seen = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (a_fs) begin
        fs_cnt++;
        if (fs_cnt == 1) fs_cyc = cyc;
      end
      if (fs_cnt == 1) begin
        if (a_de) de_cnt++;
        if (a_pf) begin
          pf_mask[a_v[2:0]] = 1'b1;
          if (a_h != 8'd11) pf_h_bad++;
        end
        if (a_v == 0 && !a_hs) hs_mask[a_h[3:0]] = 1'b1;
        if (!a_vs) vs_mask[a_v[2:0]] = 1'b1;
        if (a_v == 1 && a_h < 8) pxseq[a_h[2:0]*4 +: 4] = a_px[3:0];
        if (a_h == 0) pyseq[a_v[2:0]*4 +: 4] = a_py[3:0];
        if (a_fd && fd_v < 0) begin
          fd_h = a_h; fd_v = a_v; fs_to_fd = cyc - fs_cyc;
        end
      end
      if (c_pf && !c_pf_seen) begin
        c_pf_seen = 1'b1;
        chk("c_prefetch_h", c_h, 12);
      end
      if (c_h == 3 && c_v == 0 && !c_px_seen) begin
        c_px_seen = 1'b1;
        chk("c_px_at_h3", c_px, 1);
      end
    end
    chk("frame_starts_seen", (fs_cnt >= 2) ? 1 : 0, 1);
    chk("de_per_frame", de_cnt, 32);
    chk("prefetch_line_mask", pf_mask, 7'h47);
    chk("prefetch_h_bad", pf_h_bad, 0);
    chk("hsync_low_mask", hs_mask, 14'h0C00);
    chk("vsync_low_mask", vs_mask, 7'h20);
    chk("px_x_seq", pxseq, 32'h33221100);
    chk("px_y_seq", pyseq, 28'h0001100);
    chk("frameDrawn_h", fd_h, 0);
    chk("frameDrawn_v", fd_v, 4);
    chk("fs_to_frameDrawn", fs_to_fd, 56);
    chk("frameDrawn_period", (fd_q.size() >= 2) ? fd_q[1] - fd_q[0] : -1, 98);

    // Hold while line_start is showing: levels freeze, pulses drop.
    wait_a(0, 2);
    chk("ls_before_hold", a_ls, 1);
    n0 = fd_q.size();
    last_fd = (n0 > 0) ? fd_q[n0-1] : 0;
    enable = 1'b0;
    held_bad = 0; pulse_bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (a_h != 0 || a_v != 2 || a_de != 1'b1) held_bad++;
      if (a_ls || a_fs || a_fd || a_pf) pulse_bad++;
    end
    chk("hold_levels_bad", held_bad, 0);
    chk("hold_pulses_bad", pulse_bad, 0);
    enable = 1'b1;
    @(negedge clk);
    chk("resume_h", a_h, 1);
    chk("resume_ls", a_ls, 0);
    n = 0;
    while (fd_q.size() <= n0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("frameDrawn_shift", (fd_q.size() > n0) ? fd_q[n0] - last_fd : -1, 103);

    // Asynchronous reset in the middle of hsync on an active line.
    wait_a(10, 2);
    #2 nreset = 1'b0;
    #1;
    chk("async_rst_h", a_h, 0);
    chk("async_rst_v", a_v, 0);
    chk("async_rst_hsync", a_hs, 1);
    chk("async_rst_de", a_de, 0);
    chk("async_rst_py", a_py, 0);
    @(negedge clk);
    nreset = 1'b1;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (n == 1) chk("rst_release_h", a_h, 1);
      if (a_fs) break;
    end
    chk("rst_to_frame_start", n - 1, 97);

    repeat (20) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
